// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM unified-memory port arbiter.
// Pure declarations: no logic, no latency.
// Backpressure is expressed by the arbiter as stall_if/stall_mem.
package mem_arb_pkg;

  localparam int DefAddrW = 8;
  localparam int DefDataW = 32;
  // Width of the MEM-run fairness counter; bounds MaxMemRun to 1..15.
  localparam int RunCntW  = 4;

  // Which stage owns the read data returning this cycle.
  typedef enum logic [1:0] {
    R_NONE = 2'd0,
    R_IF   = 2'd1,
    R_MEM  = 2'd2
  } resp_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
// slave = arbiter view, master = pipeline stages plus memory view.
// Requests are held by the requester until granted; no latching inside.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AddrW = DefAddrW,
  parameter int DataW = DefDataW
) ();

  logic             req_if;
  logic [AddrW-1:0] addr_if;
  logic             flush_if;
  logic             req_mem;
  logic             we_mem;
  logic [AddrW-1:0] addr_mem;
  logic [DataW-1:0] wdata_mem;
  logic             gnt_if;
  logic             gnt_mem;
  logic             stall_if;
  logic             stall_mem;
  logic             rvalid_if;
  logic             rvalid_mem;
  logic [DataW-1:0] rdata;
  logic             mem_en;
  logic             mem_we;
  logic [AddrW-1:0] mem_addr;
  logic [DataW-1:0] mem_wdata;
  logic [DataW-1:0] mem_rdata;

  modport slave (
    input  req_if, addr_if, flush_if, req_mem, we_mem, addr_mem, wdata_mem, mem_rdata,
    output gnt_if, gnt_mem, stall_if, stall_mem, rvalid_if, rvalid_mem, rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_if, addr_if, flush_if, req_mem, we_mem, addr_mem, wdata_mem, mem_rdata,
    input  gnt_if, gnt_mem, stall_if, stall_mem, rvalid_if, rvalid_mem, rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_fair_cnt.sv
// Counts consecutive MEM grants taken while IF waits; raises force_if at the limit.
// force_if is a function of the registered count, so it is valid in the issue cycle.
// No backpressure of its own; it only tips the arbiter's priority.
module arb_fair_cnt
  import mem_arb_pkg::*;
#(
  parameter int MaxMemRun = 4
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic req_if_i,
  input  logic req_mem_i,
  input  logic gnt_if_i,
  input  logic gnt_mem_i,
  output logic force_if_o
);

  localparam logic [RunCntW-1:0] RunMax = RunCntW'(MaxMemRun);

  logic [RunCntW-1:0] run_cnt_q;
  logic [RunCntW-1:0] run_cnt_d;

  // IF has lost MaxMemRun times in a row: it must win the next contested cycle.
  assign force_if_o = req_if_i & req_mem_i & (run_cnt_q == RunMax);

  // Next count: grow while MEM beats a waiting IF, clear once IF is served or idle.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (gnt_mem_i && req_if_i) begin
      if (run_cnt_q != RunMax) begin
        run_cnt_d = run_cnt_q + 1'b1;
      end
    end else if (gnt_if_i || !req_if_i) begin
      run_cnt_d = '0;
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between IF and MEM (MEM first, IF starvation-guarded).
// Issue is combinational; read data returns one cycle later, tagged to its owner.
// Losing requester sees stall_* and must hold its request; flush_if kills IF returns.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AddrW     = DefAddrW,
  parameter int DataW     = DefDataW,
  parameter int MaxMemRun = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  mem_port_arbiter_if.slave bus
);

  logic             force_if;
  logic             gnt_if;
  logic             gnt_mem;
  logic [AddrW-1:0] addr_sel;
  logic [DataW-1:0] wdata_sel;
  logic             rvalid_if;
  logic             rvalid_mem;
  resp_state_t      resp_q;
  resp_state_t      resp_d;
  logic             kill_q;
  logic             kill_d;

  arb_fair_cnt #(
    .MaxMemRun (MaxMemRun)
  ) u_fair_cnt (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .req_if_i   (bus.req_if),
    .req_mem_i  (bus.req_mem),
    .gnt_if_i   (gnt_if),
    .gnt_mem_i  (gnt_mem),
    .force_if_o (force_if)
  );

  // Grant: MEM wins unless IF has been starved long enough; never both.
  always_comb begin
    gnt_mem = bus.req_mem & ~force_if;
    gnt_if  = bus.req_if & ~gnt_mem;
  end

  // Memory command mux: address/data from the winner, all-zero when idle.
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    if (gnt_mem) begin
      addr_sel  = bus.addr_mem;
      wdata_sel = bus.wdata_mem;
    end else if (gnt_if) begin
      addr_sel = bus.addr_if;
    end
  end

  assign bus.gnt_if    = gnt_if;
  assign bus.gnt_mem   = gnt_mem;
  assign bus.stall_if  = bus.req_if & ~gnt_if;
  assign bus.stall_mem = bus.req_mem & ~gnt_mem;
  assign bus.mem_en    = gnt_if | gnt_mem;
  assign bus.mem_we    = gnt_mem & bus.we_mem;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;

  // Remember who owns next cycle's read data, and whether an IF fetch was flushed at issue.
  always_comb begin
    resp_d = R_NONE;
    if (gnt_mem && !bus.we_mem) begin
      resp_d = R_MEM;
    end else if (gnt_if) begin
      resp_d = R_IF;
    end
    kill_d = gnt_if & bus.flush_if;
  end

  // Response tracking registers; reset drops whatever read was issued this cycle.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      resp_q <= R_NONE;
      kill_q <= 1'b0;
    end else begin
      resp_q <= resp_d;
      kill_q <= kill_d;
    end
  end

  // Route returning data; a flush in either the issue or return cycle hides IF data.
  always_comb begin
    rvalid_mem = (resp_q == R_MEM);
    rvalid_if  = (resp_q == R_IF) & ~kill_q & ~bus.flush_if;
  end

  assign bus.rvalid_if  = rvalid_if;
  assign bus.rvalid_mem = rvalid_mem;
  assign bus.rdata      = (rvalid_if | rvalid_mem) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then constrained-random traffic.
// Outputs are compared at the falling edge against a queue-free cycle model.
// A behavioural 1-cycle memory sits on the memory side of the arbiter.
module tb_mem_port_arbiter;

  localparam int AW     = 8;
  localparam int DW     = 32;
  localparam int MAXRUN = 4;

  logic Clk;
  logic Reset_n;

  mem_port_arbiter_if #(.AddrW(AW), .DataW(DW)) bus ();

  mem_port_arbiter #(.AddrW(AW), .DataW(DW), .MaxMemRun(MAXRUN)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural synchronous memory; idle cycles return junk so rdata gating is visible.
  logic [DW-1:0] mem [256];
  always @(posedge Clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 32'hBAD0_0BAD;
  end

  function automatic logic [DW-1:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  // Reference model state: expected memory, pending read owner/data, IF wait streak.
  logic [DW-1:0] ref_mem [256];
  int            m_owner;       // 0 none, 1 IF, 2 MEM
  logic [DW-1:0] m_pend;
  bit            m_kill;
  int            m_wait;        // cycles in a row IF has lost to MEM
  bit            m_gi, m_gm;

  // Last observed DUT values (sampled at the falling edge).
  logic          obs_gi, obs_gm, obs_sif, obs_mwe, obs_men, obs_rvi, obs_rvm;
  logic [DW-1:0] obs_rdata;
  int            cur_stall, max_stall;

  int n_checks, n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: check the current cycle at negedge, advance the model, cross the edge.
  task automatic tick();
    logic e_force, e_gm, e_gi, e_rvi, e_rvm;
    logic [31:0] e_addr, e_wdata, e_rdata;
    @(negedge Clk);
    e_force = bus.req_if && bus.req_mem && (m_wait >= MAXRUN);
    e_gm    = bus.req_mem && !e_force;
    e_gi    = bus.req_if && !e_gm;
    e_addr  = e_gm ? 32'(bus.addr_mem) : e_gi ? 32'(bus.addr_if) : 32'd0;
    e_wdata = e_gm ? bus.wdata_mem : 32'd0;
    e_rvm   = (m_owner == 2);
    e_rvi   = (m_owner == 1) && !m_kill && !bus.flush_if;
    e_rdata = (e_rvm || e_rvi) ? m_pend : 32'd0;

    obs_gi = bus.gnt_if;  obs_gm = bus.gnt_mem; obs_sif = bus.stall_if;
    obs_mwe = bus.mem_we; obs_men = bus.mem_en;
    obs_rvi = bus.rvalid_if; obs_rvm = bus.rvalid_mem; obs_rdata = bus.rdata;
    if (bus.stall_if) cur_stall++; else cur_stall = 0;
    if (cur_stall > max_stall) max_stall = cur_stall;

    chk("gnt_if",     32'(bus.gnt_if),     32'(e_gi));
    chk("gnt_mem",    32'(bus.gnt_mem),    32'(e_gm));
    chk("stall_if",   32'(bus.stall_if),   32'(bus.req_if && !e_gi));
    chk("stall_mem",  32'(bus.stall_mem),  32'(bus.req_mem && !e_gm));
    chk("mem_en",     32'(bus.mem_en),     32'(e_gi || e_gm));
    chk("mem_we",     32'(bus.mem_we),     32'(e_gm && bus.we_mem));
    chk("mem_addr",   32'(bus.mem_addr),   e_addr);
    chk("mem_wdata",  bus.mem_wdata,       e_wdata);
    chk("rvalid_if",  32'(bus.rvalid_if),  32'(e_rvi));
    chk("rvalid_mem", 32'(bus.rvalid_mem), 32'(e_rvm));
    chk("rdata",      bus.rdata,           e_rdata);

    m_pend = ref_mem[e_addr[7:0]];
    if (e_gm && bus.we_mem) ref_mem[e_addr[7:0]] = bus.wdata_mem;
    if (!Reset_n) begin
      m_owner = 0; m_kill = 0; m_wait = 0;
    end else begin
      m_owner = (e_gm && !bus.we_mem) ? 2 : e_gi ? 1 : 0;
      m_kill  = e_gi && bus.flush_if;
      if (bus.req_if && !e_gi) m_wait = (m_wait + 1 > MAXRUN) ? MAXRUN : m_wait + 1;
      else                     m_wait = 0;
    end
    m_gi = e_gi; m_gm = e_gm;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.req_if = 0; bus.req_mem = 0; bus.we_mem = 0; bus.flush_if = 0;
    bus.addr_if = '0; bus.addr_mem = '0; bus.wdata_mem = '0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cur_stall = 0; max_stall = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    mem[4] = 32'h2008_0005;
    ref_mem[4] = 32'h2008_0005;
    m_owner = 0; m_kill = 0; m_wait = 0; m_pend = '0; m_gi = 0; m_gm = 0;
    Reset_n = 0;
    idle();

    // Reset for two cycles, then release with no requests.
    @(posedge Clk); #1;
    tick();
    Reset_n = 1;
    tick();
    chk("reset_mem_en", 32'(obs_men), 32'd0);
    chk("reset_rdata",  obs_rdata,    32'd0);

    // IF-only read of word 4.
    bus.req_if = 1; bus.addr_if = 8'h04;
    tick();
    chk("if_issue_gnt", 32'(obs_gi), 32'd1);
    bus.req_if = 0;
    tick();
    chk("if_ret_rvalid", 32'(obs_rvi), 32'd1);
    chk("if_ret_rdata",  obs_rdata,    32'h2008_0005);

    // Contention: MEM read of 0x10 beats IF, IF wins the next cycle.
    bus.req_if = 1; bus.addr_if = 8'h08;
    bus.req_mem = 1; bus.we_mem = 0; bus.addr_mem = 8'h10;
    tick();
    chk("cont_gnt_mem",  32'(obs_gm),  32'd1);
    chk("cont_stall_if", 32'(obs_sif), 32'd1);
    bus.req_mem = 0;
    tick();
    chk("cont_rvalid_mem", 32'(obs_rvm), 32'd1);
    chk("cont_gnt_if",     32'(obs_gi),  32'd1);
    chk("cont_rdata",      obs_rdata,    init_word(16));
    bus.req_if = 0;
    tick();

    // Fairness: both held, MEM alternating write/read: 4 MEM grants then 1 IF grant.
    max_stall = 0; cur_stall = 0;
    bus.req_if = 1; bus.addr_if = 8'h30;
    bus.req_mem = 1; bus.we_mem = 1; bus.addr_mem = 8'h40; bus.wdata_mem = $urandom;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("fair_pattern", 32'(obs_gi), 32'((k % 5) == 4));
      if (m_gm) begin
        bus.we_mem = ~bus.we_mem;
        bus.addr_mem = bus.addr_mem + 8'd1;
        bus.wdata_mem = $urandom;
      end
    end
    chk("fair_max_stall", 32'(max_stall <= MAXRUN), 32'd1);
    idle();
    tick();

    // Flush in the issue cycle.
    bus.req_if = 1; bus.addr_if = 8'h04; bus.flush_if = 1;
    tick();
    chk("flush_issue_men", 32'(obs_men), 32'd1);
    bus.req_if = 0; bus.flush_if = 0;
    tick();
    chk("flush_issue_rvi", 32'(obs_rvi), 32'd0);
    // Flush in the return cycle.
    bus.req_if = 1;
    tick();
    chk("flush_ret_men", 32'(obs_men), 32'd1);
    bus.req_if = 0; bus.flush_if = 1;
    tick();
    chk("flush_ret_rvi", 32'(obs_rvi), 32'd0);
    bus.flush_if = 0;

    // MEM write then read-back; reset during a second read's issue cycle drops it.
    bus.req_mem = 1; bus.we_mem = 1; bus.addr_mem = 8'h20; bus.wdata_mem = 32'hDEAD_BEEF;
    tick();
    chk("wr_mem_we",  32'(obs_mwe), 32'd1);
    chk("wr_rvalid",  32'(obs_rvm | obs_rvi), 32'd0);
    bus.we_mem = 0;
    tick();
    Reset_n = 0;
    tick();
    chk("rd_rvalid_mem", 32'(obs_rvm), 32'd1);
    chk("rd_rdata",      obs_rdata,    32'hDEAD_BEEF);
    Reset_n = 1; bus.req_mem = 0;
    tick();
    chk("rst_drop_rvm", 32'(obs_rvm), 32'd0);

    // Random traffic; a stalled requester holds its request.
    for (int c = 0; c < 600; c++) begin
      Reset_n = ($urandom_range(0, 39) != 0);
      if (!bus.req_if || m_gi) begin
        bus.req_if  = ($urandom_range(0, 2) != 0);
        bus.addr_if = 8'($urandom_range(0, 15));
      end
      if (!bus.req_mem || m_gm) begin
        bus.req_mem   = ($urandom_range(0, 2) != 0);
        bus.we_mem    = $urandom_range(0, 1) == 1;
        bus.addr_mem  = 8'($urandom_range(0, 15));
        bus.wdata_mem = $urandom;
      end
      bus.flush_if = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch stage (IF) and data-memory stage (MEM).
- Grants at most one access per cycle, with MEM having priority over IF.
- Issues stall signals to each stage and routes the 1-cycle-latency read data back to the stage that issued the read.
- A starvation counter guarantees IF forward progress; flush_if cancels an in-flight fetch when a branch or jump redirects the PC.

Parameters:
- AddrW, 8, word-address width; memory depth is 2^AddrW words.
- DataW, 32, data width.
- MaxMemRun, 4, maximum consecutive MEM grants while IF is waiting before IF is forced a grant. Legal range 1..15.

Ports:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  synchronous, active-low reset
- req_if  in  1  IF read request, held until granted
- addr_if  in  AddrW  IF word address
- flush_if  in  1  kill any IF read granted this cycle or returning this cycle
- req_mem  in  1  MEM request, held until granted
- we_mem  in  1  1 = write, 0 = read
- addr_mem  in  AddrW  MEM word address
- wdata_mem  in  DataW  MEM write data
- gnt_if  out  1  IF access issued this cycle
- gnt_mem  out  1  MEM access issued this cycle
- stall_if  out  1  req_if & ~gnt_if
- stall_mem  out  1  req_mem & ~gnt_mem
- rvalid_if  out  1  rdata is IF read result
- rvalid_mem  out  1  rdata is MEM read result
- rdata  out  DataW  returned read data
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  AddrW  memory address
- mem_wdata  out  DataW  memory write data
- mem_rdata  in  DataW  memory read data, valid the cycle after a read issue

Behaviour:
- Issue (combinational, cycle N):
  - If req_mem and not force_if: gnt_mem=1.
  - Else if req_if: gnt_if=1.
  - Else no grant.
  - force_if = req_if & req_mem & (run_cnt == MaxMemRun).
  - At most one grant per cycle.
  - mem_en = gnt_if | gnt_mem. mem_we = gnt_mem & we_mem.
  - mem_addr/mem_wdata come from the granted requester; they are 0 when mem_en=0.
- Response owner register (resp_state), updated each edge:
  - R_NONE: no read in flight.
  - R_IF: an IF read was issued last cycle.
  - R_MEM: a MEM read was issued last cycle.
  - Next state: R_MEM if gnt_mem & ~we_mem; R_IF if gnt_if; else R_NONE.
  - Back-to-back reads are fully pipelined: one read issued per cycle, each returned one cycle later.
- Response (cycle N+1):
  - rvalid_mem = (resp_state==R_MEM).
  - rvalid_if = (resp_state==R_IF) & ~kill_q & ~flush_if.
  - rdata = mem_rdata when either rvalid is 1, else 0.
  - Writes complete in the issue cycle and never assert rvalid.
- kill_q register: set to (gnt_if & flush_if) at each edge, cleared otherwise. flush_if in the issue cycle or the return cycle suppresses that fetch's rvalid_if.
- Fairness counter run_cnt (4 bits):
  - gnt_mem & req_if: increment, saturating at MaxMemRun.
  - gnt_if, or ~req_if: reset to 0.
  - Otherwise: hold.
- Simultaneous flush_if and req_if in the same cycle: the grant still proceeds, and that fetch is killed.
- Reset (Reset_n=0 at an edge):
  - resp_state=R_NONE, kill_q=0, run_cnt=0.
  - All registered outputs are 0 the following cycle; rvalid_if/rvalid_mem are 0 from that cycle onward.
  - Combinational grants remain live during reset, but any read issued then is discarded.
- A requester must hold its address and data stable while stalled. The arbiter does not latch requests.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef resp_state_t {R_NONE, R_IF, R_MEM};
  - localparams for the default AddrW/DataW;
  - the run_cnt width constant.
- One natural sub-module: arb_fair_cnt, containing the saturating run counter and the force_if generation.
- Grant mux and response tracking stay in the top module.

Test Plan:
- Reset_n=0 for 2 cycles, then release with no requests.
  -> All outputs 0. mem_en=0. No rvalid.
- IF read only, addr_if=8'h04, memory word 4=32'h20080005.
  -> Cycle N: gnt_if=1, mem_addr=4.
  -> Cycle N+1: rvalid_if=1, rdata=32'h20080005.
- req_if and req_mem (read, addr 8'h10) together.
  -> gnt_mem=1, stall_if=1.
  -> Next cycle: rvalid_mem=1 and gnt_if=1.
- req_mem held continuously (alternating write/read) with req_if held, MaxMemRun=4.
  -> 4 MEM grants, then 1 IF grant, then the pattern repeats.
  -> stall_if is never high for more than 4 consecutive cycles.
- IF read granted with flush_if=1 in the issue cycle; separately, flush_if=1 only in the return cycle.
  -> rvalid_if=0 in both cases; the memory access still occurs.
- MEM write (addr 8'h20, data 32'hDEADBEEF) followed by MEM read of 8'h20.
  -> Write: mem_we=1 and no rvalid.
  -> Read returns 32'hDEADBEEF with rvalid_mem=1.
  -> Reset_n asserted in the read's issue cycle causes rvalid_mem=0 in the next cycle.
